// File: rtl/axi_stream_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream slave sink: buffer state
// encoding, TKEEP popcount and a width-bounded saturating add.
package axi_stream_sink_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned MAX_BYTES = 64;

  function automatic logic [6:0] popcount(input logic [MAX_BYTES-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_BYTES; i++) n = n + 7'(v[i]);
    return n;
  endfunction

  // a + b clamped to the all-ones value of a w-bit counter
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] maxv;
    logic [64:0] s;
    maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s    = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[63:0];
  endfunction

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry skid buffer with a registered input ready; payload width W is
// opaque. Ready drops only once both the output and skid registers hold data.
module axi_stream_skid_buffer
  import axi_stream_sink_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_e   state_q;
  logic         ready_q;
  logic         valid_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         acc;
  logic         pop;

  assign acc         = in_valid_i && ready_q;
  assign pop         = valid_q && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = out_q;

  // Data registers are not reset; valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          ready_q <= 1'b1;
          if (acc) begin
            out_q   <= in_data_i;
            valid_q <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (acc && !pop) begin
            skid_q  <= in_data_i;
            ready_q <= 1'b0;
            state_q <= BUF_FULL;
          end else if (pop && !acc) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= BUF_EMPTY;
          end else begin
            ready_q <= 1'b1;
            if (acc) out_q <= in_data_i;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        default: begin
          state_q <= BUF_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_stream_slave_sink.sv
// AXI4-Stream ingress sink: skid-buffered forwarding plus per-packet stats.
// Define AXIS_SINK_PROTOCOL_CHECK_EN to build the sticky master-side checker.
module axi_stream_slave_sink
  import axi_stream_sink_pkg::*;
#(
  parameter int BYTE_WIDTH    = 4,
  parameter int USER_WIDTH    = 1,
  parameter int CNT_WIDTH     = 16,
  parameter int PKT_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [8*BYTE_WIDTH-1:0]  s_tdata,
  input  logic [BYTE_WIDTH-1:0]    s_tstrb,
  input  logic [BYTE_WIDTH-1:0]    s_tkeep,
  input  logic                     s_tlast,
  input  logic [USER_WIDTH-1:0]    s_tuser,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [8*BYTE_WIDTH-1:0]  m_data,
  output logic [BYTE_WIDTH-1:0]    m_keep,
  output logic                     m_last,
  output logic [USER_WIDTH-1:0]    m_user,
  output logic                     pkt_done,
  output logic [CNT_WIDTH-1:0]     pkt_beats,
  output logic [CNT_WIDTH-1:0]     pkt_bytes,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     err_drop,
  output logic                     err_unstable,
  output logic                     err_strb
);

  localparam int DW = 8 * BYTE_WIDTH;
  localparam int PW = DW + BYTE_WIDTH + 1 + USER_WIDTH;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;
  logic          acc;

  assign in_pl = {s_tuser, s_tlast, s_tkeep, s_tdata};
  assign {m_user, m_last, m_keep, m_data} = out_pl;
  assign acc = s_tvalid && s_tready;

  axi_stream_skid_buffer #(.W(PW)) u_skid (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid_i  (s_tvalid),
    .in_ready_o  (s_tready),
    .in_data_i   (in_pl),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .out_data_o  (out_pl)
  );

  logic [CNT_WIDTH-1:0]     run_beats_q, run_beats_d;
  logic [CNT_WIDTH-1:0]     run_bytes_q, run_bytes_d;
  logic [CNT_WIDTH-1:0]     pkt_beats_q, pkt_beats_d;
  logic [CNT_WIDTH-1:0]     pkt_bytes_q, pkt_bytes_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                     pkt_done_q, pkt_done_d;
  logic [CNT_WIDTH-1:0]     beats_nx;
  logic [CNT_WIDTH-1:0]     bytes_nx;
  logic [MAX_BYTES-1:0]     keep_ext;

  assign keep_ext = MAX_BYTES'(s_tkeep);

  // Totals include the current beat so a TLAST beat reports the full packet.
  always_comb begin
    beats_nx    = CNT_WIDTH'(sat_add(64'(run_beats_q), 64'd1, CNT_WIDTH));
    bytes_nx    = CNT_WIDTH'(sat_add(64'(run_bytes_q), 64'(popcount(keep_ext)), CNT_WIDTH));
    run_beats_d = run_beats_q;
    run_bytes_d = run_bytes_q;
    pkt_beats_d = pkt_beats_q;
    pkt_bytes_d = pkt_bytes_q;
    pkt_count_d = pkt_count_q;
    pkt_done_d  = 1'b0;
    if (acc) begin
      if (s_tlast) begin
        pkt_beats_d = beats_nx;
        pkt_bytes_d = bytes_nx;
        run_beats_d = '0;
        run_bytes_d = '0;
        pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
        pkt_done_d  = 1'b1;
      end else begin
        run_beats_d = beats_nx;
        run_bytes_d = bytes_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_beats_q <= '0;
      run_bytes_q <= '0;
      pkt_beats_q <= '0;
      pkt_bytes_q <= '0;
      pkt_count_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      run_beats_q <= run_beats_d;
      run_bytes_q <= run_bytes_d;
      pkt_beats_q <= pkt_beats_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_count_q <= pkt_count_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign pkt_done  = pkt_done_q;
  assign pkt_beats = pkt_beats_q;
  assign pkt_bytes = pkt_bytes_q;
  assign pkt_count = pkt_count_q;

`ifdef AXIS_SINK_PROTOCOL_CHECK_EN
  localparam int CW = DW + 2 * BYTE_WIDTH + 1 + USER_WIDTH;

  logic [CW-1:0] chk_pl;
  logic [CW-1:0] chk_pl_q;
  logic          stall_q;
  logic          arm_q;
  logic          err_drop_q, err_unstable_q, err_strb_q;

  assign chk_pl = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tuser};

  // stall_q is only ever set out of reset, so it doubles as the arm for the
  // hold checks; arm_q gates the strobe check for the first edge after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q        <= 1'b0;
      arm_q          <= 1'b0;
      err_drop_q     <= 1'b0;
      err_unstable_q <= 1'b0;
      err_strb_q     <= 1'b0;
    end else begin
      arm_q    <= 1'b1;
      stall_q  <= s_tvalid && !s_tready;
      chk_pl_q <= chk_pl;
      if (stall_q && !s_tvalid) err_drop_q <= 1'b1;
      if (stall_q && (chk_pl != chk_pl_q)) err_unstable_q <= 1'b1;
      if (arm_q && s_tvalid && |(s_tstrb & ~s_tkeep)) err_strb_q <= 1'b1;
    end
  end

  assign err_drop     = err_drop_q;
  assign err_unstable = err_unstable_q;
  assign err_strb     = err_strb_q;
`else
  logic unused_strb;
  assign unused_strb  = ^s_tstrb;
  assign err_drop     = 1'b0;
  assign err_unstable = 1'b0;
  assign err_strb     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_slave_sink.sv
// Self-checking bench for axi_stream_slave_sink: a directed vector table,
// then model-checked sequences (saturation, back-pressure, random, protocol, reset).
module tb_axi_stream_slave_sink;

  localparam int BW   = 4;
  localparam int UW   = 2;
  localparam int CW   = 6;
  localparam int PCW  = 32;
  localparam int MAXC = (1 << CW) - 1;
`ifdef AXIS_SINK_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn;
  logic           s_tvalid;
  logic           s_tready;
  logic [8*BW-1:0] s_tdata;
  logic [BW-1:0]  s_tstrb;
  logic [BW-1:0]  s_tkeep;
  logic           s_tlast;
  logic [UW-1:0]  s_tuser;
  logic           m_valid;
  logic           m_ready;
  logic [8*BW-1:0] m_data;
  logic [BW-1:0]  m_keep;
  logic           m_last;
  logic [UW-1:0]  m_user;
  logic           pkt_done;
  logic [CW-1:0]  pkt_beats;
  logic [CW-1:0]  pkt_bytes;
  logic [PCW-1:0] pkt_count;
  logic           err_drop, err_unstable, err_strb;

  always #5 clk = ~clk;

  axi_stream_slave_sink #(
    .BYTE_WIDTH(BW), .USER_WIDTH(UW), .CNT_WIDTH(CW), .PKT_CNT_WIDTH(PCW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_user(m_user),
    .pkt_done(pkt_done), .pkt_beats(pkt_beats), .pkt_bytes(pkt_bytes), .pkt_count(pkt_count),
    .err_drop(err_drop), .err_unstable(err_unstable), .err_strb(err_strb)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [8*BW-1:0] data;
    logic [BW-1:0]   keep;
    logic            last;
    logic [UW-1:0]   user;
  } beat_t;

  beat_t q[$];
  int    run_b, run_y, exp_beats, exp_bytes;
  int unsigned exp_count;
  bit    exp_tready, exp_mvalid, exp_done, last_acc;
  bit    exp_edrop, exp_eunst, exp_estrb;

  // Advance one clock edge, updating the model from the inputs now applied,
  // then compare every observable output.
  task automatic mcycle();
    bit acc, pop;
    beat_t b;
    acc = resetn && s_tvalid && exp_tready;
    pop = resetn && exp_mvalid && m_ready;
    last_acc = acc;
    if (!resetn) begin
      q.delete();
      run_b = 0; run_y = 0; exp_beats = 0; exp_bytes = 0; exp_count = 0;
      exp_tready = 0; exp_mvalid = 0; exp_done = 0;
      exp_edrop = 0; exp_eunst = 0; exp_estrb = 0;
    end else begin
      if (pop) void'(q.pop_front());
      exp_done = 0;
      if (acc) begin
        b.data = s_tdata; b.keep = s_tkeep; b.last = s_tlast; b.user = s_tuser;
        q.push_back(b);
        run_b = (run_b + 1 > MAXC) ? MAXC : run_b + 1;
        run_y = (run_y + $countones(s_tkeep) > MAXC) ? MAXC : run_y + $countones(s_tkeep);
        if (s_tlast) begin
          exp_beats = run_b; exp_bytes = run_y;
          run_b = 0; run_y = 0;
          exp_count++;
          exp_done = 1;
        end
      end
      exp_tready = (q.size() < 2);
      exp_mvalid = (q.size() > 0);
    end
    @(posedge clk); #1;
    chk("s_tready", s_tready, exp_tready);
    chk("m_valid", m_valid, exp_mvalid);
    chk("pkt_done", pkt_done, exp_done);
    chk("pkt_beats", pkt_beats, exp_beats);
    chk("pkt_bytes", pkt_bytes, exp_bytes);
    chk("pkt_count", pkt_count, exp_count);
    chk("err_drop", err_drop, exp_edrop);
    chk("err_unstable", err_unstable, exp_eunst);
    chk("err_strb", err_strb, exp_estrb);
    if (exp_mvalid && q.size() > 0) begin
      chk("m_data", m_data, q[0].data);
      chk("m_keep", m_keep, q[0].keep);
      chk("m_last", m_last, q[0].last);
      chk("m_user", m_user, q[0].user);
    end
  endtask

  task automatic set_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tstrb = k; s_tlast = l; s_tuser = UW'(d);
  endtask

  // Offer one beat and hold it until the model says it was accepted.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    set_beat(d, k, l);
    n = 0;
    do begin
      mcycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted data=%0h", d);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic mreset();
    resetn = 1'b0; s_tvalid = 1'b0;
    mcycle(); mcycle();
    resetn = 1'b1;
    mcycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rstn, tvalid;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last, mready;
    logic        e_tready, e_mvalid;
    logic [31:0] e_data;
    logic        e_done;
    int          e_beats, e_bytes, e_count;
  } vec_t;

  vec_t vecs[13];

  initial begin
    resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
    s_tlast = 1'b0; s_tuser = '0; m_ready = 1'b0;
    last_acc = 0; exp_tready = 0; exp_mvalid = 0;

    // rstn tv data keep last mrdy | tready mvalid data done beats bytes count
    vecs[0]  = '{1,1,32'hA0000001,4'hF,0,1, 1,0,32'h0,       0,0,0,0};
    vecs[1]  = '{1,1,32'hA0000001,4'hF,0,1, 1,1,32'hA0000001,0,0,0,0};
    vecs[2]  = '{1,1,32'hA0000002,4'hF,0,1, 1,1,32'hA0000002,0,0,0,0};
    vecs[3]  = '{1,1,32'hA0000003,4'hF,1,1, 1,1,32'hA0000003,1,3,12,1};
    vecs[4]  = '{1,1,32'hB0000001,4'hF,0,1, 1,1,32'hB0000001,0,3,12,1};
    vecs[5]  = '{1,1,32'hB0000002,4'h3,1,1, 1,1,32'hB0000002,1,2,6,2};
    vecs[6]  = '{1,0,32'h0,       4'h0,0,1, 1,0,32'h0,       0,2,6,2};
    vecs[7]  = '{1,1,32'hC0000001,4'hF,0,0, 1,1,32'hC0000001,0,2,6,2};
    vecs[8]  = '{1,1,32'hC0000002,4'hF,0,0, 0,1,32'hC0000001,0,2,6,2};
    vecs[9]  = '{1,1,32'hC0000003,4'hF,1,0, 0,1,32'hC0000001,0,2,6,2};
    vecs[10] = '{1,1,32'hC0000003,4'hF,1,1, 1,1,32'hC0000002,0,2,6,2};
    vecs[11] = '{1,1,32'hC0000003,4'hF,1,1, 1,1,32'hC0000003,1,3,12,3};
    vecs[12] = '{1,0,32'h0,       4'h0,0,1, 1,0,32'h0,       0,3,12,3};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_beats", pkt_beats, 0);
    chk("rst_bytes", pkt_bytes, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_errs", {err_drop, err_unstable, err_strb}, 0);

    for (int i = 0; i < 13; i++) begin
      resetn = vecs[i].rstn; s_tvalid = vecs[i].tvalid; s_tdata = vecs[i].data;
      s_tkeep = vecs[i].keep; s_tstrb = vecs[i].keep; s_tlast = vecs[i].last;
      s_tuser = '0; m_ready = vecs[i].mready;
      @(posedge clk); #1;
      chk($sformatf("v%0d_tready", i), s_tready, vecs[i].e_tready);
      chk($sformatf("v%0d_mvalid", i), m_valid, vecs[i].e_mvalid);
      if (vecs[i].e_mvalid) chk($sformatf("v%0d_mdata", i), m_data, vecs[i].e_data);
      chk($sformatf("v%0d_done", i), pkt_done, vecs[i].e_done);
      chk($sformatf("v%0d_beats", i), pkt_beats, 64'(vecs[i].e_beats));
      chk($sformatf("v%0d_bytes", i), pkt_bytes, 64'(vecs[i].e_bytes));
      chk($sformatf("v%0d_count", i), pkt_count, 64'(vecs[i].e_count));
    end

    // ---------------- model-checked sequences ----------------
    mreset();

    // saturation: 70-beat packet of 4-byte beats overflows a 6-bit counter
    m_ready = 1'b1;
    for (int i = 0; i < 70; i++) send(32'h5A000000 + i, 4'hF, i == 69);
    chk("sat_beats", pkt_beats, MAXC);
    chk("sat_bytes", pkt_bytes, MAXC);
    send(32'h11110000, 4'hF, 0);
    send(32'h11110001, 4'h3, 1);
    chk("two_beat_bytes", pkt_bytes, 6);
    chk("two_beat_beats", pkt_beats, 2);

    // continuous input with a 4-cycle consumer stall
    begin
      int n;
      n = 0;
      for (int c = 0; c < 16; c++) begin
        m_ready = !(c >= 2 && c < 6);
        if (!s_tvalid || last_acc) begin
          if (n < 8) begin set_beat(32'hD0000000 + n, 4'hF, n == 7); n++; end
          else s_tvalid = 1'b0;
        end
        mcycle();
        if (c == 5) chk("stall_full_tready", s_tready, 0);
      end
      s_tvalid = 1'b0; m_ready = 1'b1;
      repeat (3) mcycle();
      chk("stall_count", pkt_count, exp_count);
      chk("stall_drained", m_valid, 0);
    end

    // randomized legal traffic
    last_acc = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!(s_tvalid && !last_acc)) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = $urandom;
        s_tkeep  = 4'($urandom);
        s_tstrb  = s_tkeep & 4'($urandom);
        s_tlast  = ($urandom_range(0, 5) == 0);
        s_tuser  = UW'($urandom);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      mcycle();
    end
    s_tvalid = 1'b0; m_ready = 1'b1;
    repeat (3) mcycle();

    // reset mid-packet with two beats buffered
    m_ready = 1'b0;
    send(32'hE0000001, 4'hF, 0);
    send(32'hE0000002, 4'hF, 0);
    chk("pre_rst_full", s_tready, 0);
    resetn = 1'b0;
    mcycle();
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_count", pkt_count, 0);
    resetn = 1'b1; m_ready = 1'b1;
    mcycle();
    send(32'hF0000001, 4'hF, 0);
    send(32'hF0000002, 4'h1, 1);
    chk("post_rst_beats", pkt_beats, 2);
    chk("post_rst_bytes", pkt_bytes, 5);
    chk("post_rst_count", pkt_count, 1);
    mcycle();

    // protocol violations while stalled
    mreset();
    m_ready = 1'b0;
    send(32'h90000001, 4'hF, 0);
    send(32'h90000002, 4'hF, 0);
    set_beat(32'h90000003, 4'hF, 0);
    mcycle();
    s_tdata = 32'h9000FFFF;
    exp_eunst = CHK;
    mcycle();
    s_tvalid = 1'b0;
    exp_edrop = CHK;
    mcycle();
    set_beat(32'h90000004, 4'h0, 1);
    s_tstrb = 4'h1;
    exp_estrb = CHK;
    mcycle();
    mcycle();
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (last_acc) s_tvalid = 1'b0;
      mcycle();
    end
    chk("sticky_errs", {err_drop, err_unstable, err_strb}, {CHK, CHK, CHK});
    resetn = 1'b0;
    mcycle();
    chk("errs_cleared", {err_drop, err_unstable, err_strb}, 0);
    resetn = 1'b1;
    mcycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
